// File: rtl/alu_unit_if.sv
// Command/operand and write-back bundle between the register-file side and alu_unit.
// The master drives the request; the slave (the ALU) drives status and write-back.
interface alu_unit_if #(parameter int WIDTH = 8);
  logic             start;
  logic [2:0]       op;
  logic [2:0]       dest;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             we;
  logic [2:0]       waddr;
  logic [WIDTH-1:0] result;
  logic             zf;
  logic             cf;
  logic             nf;

  modport master (output start, op, dest, a, b,
                  input  busy, done, we, waddr, result, zf, cf, nf);
  modport slave  (input  start, op, dest, a, b,
                  output busy, done, we, waddr, result, zf, cf, nf);
endinterface

// File: rtl/alu_unit.sv
// Sequenced 8-bit ALU: single-cycle logic/arithmetic ops plus an 8-iteration shift-add
// multiply, with registered result/flags and a one-cycle register-file write-back strobe.
module alu_unit #(parameter int WIDTH = 8) (
  input  logic       clk,
  input  logic       rst_n,
  alu_unit_if.slave  bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam logic [2:0] LAST_ITER = 3'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

  state_t             state;
  state_t             state_next;
  logic [2:0]         op_q;
  logic [2:0]         dest_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mul_add;
  logic [WIDTH-1:0]   mplier;
  logic [2:0]         cnt;
  logic [WIDTH-1:0]   result_q;
  logic               zf_q;
  logic               cf_q;
  logic               nf_q;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   exec_res;
  logic               exec_cf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = (bus.op == OP_MUL) ? MUL : EXEC;
      EXEC:    state_next = WB;
      MUL:     if (cnt == LAST_ITER) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle ops work only on the operands latched at start.
  always_comb begin
    sum      = '0;
    exec_res = '0;
    exec_cf  = 1'b0;
    case (op_q)
      OP_ADD: begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        exec_res = sum[WIDTH-1:0];
        exec_cf  = sum[WIDTH];
      end
      OP_SUB: begin
        exec_res = a_q - b_q;
        exec_cf  = (a_q < b_q);
      end
      OP_AND: exec_res = a_q & b_q;
      OP_OR:  exec_res = a_q | b_q;
      OP_XOR: exec_res = a_q ^ b_q;
      OP_SHL: begin
        exec_res = {a_q[WIDTH-2:0], 1'b0};
        exec_cf  = a_q[WIDTH-1];
      end
      OP_SHR: begin
        exec_res = {1'b0, a_q[WIDTH-1:1]};
        exec_cf  = a_q[0];
      end
      default: begin
        exec_res = '0;
        exec_cf  = 1'b0;
      end
    endcase
  end

  assign mul_add = prod + (mplier[0] ? mcand : '0);

  // Result and flags load only on the edge that enters WB, so they hold between ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      dest_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      cnt      <= '0;
      result_q <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      nf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            dest_q <= bus.dest;
            a_q    <= bus.a;
            b_q    <= bus.b;
            mcand  <= {{WIDTH{1'b0}}, bus.a};
            mplier <= bus.b;
            prod   <= '0;
            cnt    <= '0;
          end
        end
        EXEC: begin
          result_q <= exec_res;
          cf_q     <= exec_cf;
          zf_q     <= (exec_res == '0);
          nf_q     <= exec_res[WIDTH-1];
        end
        MUL: begin
          prod   <= mul_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
          if (cnt == LAST_ITER) begin
            result_q <= mul_add[WIDTH-1:0];
            cf_q     <= (mul_add[2*WIDTH-1:WIDTH] != '0);
            zf_q     <= (mul_add[WIDTH-1:0] == '0);
            nf_q     <= mul_add[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == WB);
  assign bus.we     = (state == WB);
  assign bus.waddr  = dest_q;
  assign bus.result = result_q;
  assign bus.zf     = zf_q;
  assign bus.cf     = cf_q;
  assign bus.nf     = nf_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed and random ops against an arithmetic
// reference model, held-start throughput, and reset abort in the middle of a multiply.
module tb_alu_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_unit_if #(.WIDTH(8)) bus ();

  alu_unit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  // Reference model: plain integer arithmetic on the op's definition.
  task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic c);
    int full;
    full = 0;
    c    = 1'b0;
    case (op)
      3'd0: begin full = int'(a) + int'(b); c = (full > 255); end
      3'd1: begin full = int'(a) - int'(b) + 256; c = (int'(a) < int'(b)); end
      3'd2: full = int'(a & b);
      3'd3: full = int'(a | b);
      3'd4: full = int'(a ^ b);
      3'd5: begin full = int'(a) * 2; c = (int'(a) >= 128); end
      3'd6: begin full = int'(a) / 2; c = (int'(a) % 2 == 1); end
      default: begin full = int'(a) * int'(b); c = (full > 255); end
    endcase
    r = 8'(full % 256);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] dest, input bit scramble);
    logic [7:0] er;
    logic       ec;
    int         cycles;
    int         lat;
    model(op, a, b, er, ec);
    lat = (op == 3'd7) ? 8 : 1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.dest  = dest;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", 16'(bus.busy), 16'd1);
    cycles = 0;
    while (!bus.we && cycles < 20) begin
      if (scramble) begin
        bus.a  = 8'($urandom);
        bus.b  = 8'($urandom);
        bus.op = 3'($urandom);
      end
      @(posedge clk); #1;
      cycles++;
    end
    check("latency", 16'(cycles), 16'(lat));
    check("done", 16'(bus.done), 16'd1);
    check("waddr", 16'(bus.waddr), 16'(dest));
    check("result", 16'(bus.result), 16'(er));
    check("cf", 16'(bus.cf), 16'(ec));
    check("zf", 16'(bus.zf), 16'(er == 8'd0));
    check("nf", 16'(bus.nf), 16'(er[7]));
    @(posedge clk); #1;
    check("we_single", 16'(bus.we), 16'd0);
    check("busy_end", 16'(bus.busy), 16'd0);
    check("result_held", 16'(bus.result), 16'(er));
  endtask

  initial begin
    int pulses;
    int doubles;
    bit prev_we;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.dest  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_done", 16'(bus.done), 16'd0);
    check("rst_we", 16'(bus.we), 16'd0);
    check("rst_waddr", 16'(bus.waddr), 16'd0);
    check("rst_result", 16'(bus.result), 16'd0);
    check("rst_flags", 16'({bus.zf, bus.cf, bus.nf}), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed ops");
    run_op(3'd0, 8'hF0, 8'h20, 3'd2, 1'b0);
    run_op(3'd1, 8'h05, 8'h05, 3'd3, 1'b0);
    run_op(3'd1, 8'h03, 8'h05, 3'd4, 1'b0);
    run_op(3'd7, 8'h13, 8'h11, 3'd1, 1'b0);
    run_op(3'd7, 8'h0F, 8'h0F, 3'd6, 1'b1);
    run_op(3'd5, 8'h81, 8'h00, 3'd0, 1'b1);
    run_op(3'd6, 8'h01, 8'hFF, 3'd7, 1'b1);
    run_op(3'd2, 8'hCC, 8'h0F, 3'd5, 1'b1);
    run_op(3'd4, 8'hAA, 8'hAA, 3'd1, 1'b0);

    $display("[TB] random ops");
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
             3'($urandom), 1'($urandom));
    end

    $display("[TB] start held high with OR");
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd3;
    bus.a     = 8'h5A;
    bus.b     = 8'h81;
    bus.dest  = 3'd3;
    pulses  = 0;
    doubles = 0;
    prev_we = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.we) pulses++;
      if (bus.we && prev_we) doubles++;
      prev_we = bus.we;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("held_pulses", 16'(pulses), 16'd10);
    check("held_back_to_back", 16'(doubles), 16'd0);
    check("held_result", 16'(bus.result), 16'hDB);

    $display("[TB] reset during multiply");
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd7;
    bus.a     = 8'h13;
    bus.b     = 8'h11;
    bus.dest  = 3'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 16'(bus.busy), 16'd0);
    check("abort_we", 16'(bus.we), 16'd0);
    check("abort_waddr", 16'(bus.waddr), 16'd0);
    check("abort_result", 16'(bus.result), 16'd0);
    check("abort_flags", 16'({bus.zf, bus.cf, bus.nf}), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.we) pulses++;
    end
    check("abort_no_writeback", 16'(pulses), 16'd0);
    run_op(3'd0, 8'h7F, 8'h01, 3'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
